// File: rtl/vga_pattern_gen_if.sv
// VGA pattern generator video bundle: pattern controls in, timing and colour out.
// The generator side takes the master modport.
interface vga_pattern_gen_if #(
  parameter int COLOR_W = 4
);
  logic [2:0]         sw;
  logic [1:0]         mode;
  logic               h_sync;
  logic               v_sync;
  logic [COLOR_W-1:0] red;
  logic [COLOR_W-1:0] green;
  logic [COLOR_W-1:0] blue;
  logic               active;
  logic               frame_start;
  logic [11:0]        pix_x;
  logic [11:0]        pix_y;

  modport master (
    input  sw, mode,
    output h_sync, v_sync, red, green, blue,
    output active, frame_start, pix_x, pix_y
  );

  modport slave (
    output sw, mode,
    input  h_sync, v_sync, red, green, blue,
    input  active, frame_start, pix_x, pix_y
  );
endinterface

// File: rtl/vga_pattern_gen.sv
// VGA timing generator with four test patterns.
// Every output is registered one cycle behind the h/v counters.
module vga_pattern_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int COLOR_W  = 4,
  parameter bit SYNC_POL = 1'b0
) (
  input logic            clk,
  input logic            rst,
  vga_pattern_gen_if.master vid
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [11:0] H_LAST = 12'(H_TOTAL - 1);
  localparam logic [11:0] V_LAST = 12'(V_TOTAL - 1);
  localparam logic [11:0] H_VIS  = 12'(H_ACTIVE);
  localparam logic [11:0] V_VIS  = 12'(V_ACTIVE);
  localparam logic [11:0] HS_BEG = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] HS_END = 12'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [11:0] VS_BEG = 12'(V_ACTIVE + V_FP);
  localparam logic [11:0] VS_END = 12'(V_ACTIVE + V_FP + V_SYNC);

  logic [11:0] h;
  logic [11:0] v;
  logic [2:0]  sw_s;
  logic [1:0]  mode_s;

  logic h_end;
  logic v_end;
  logic vis;
  logic hs_on;
  logic vs_on;

  assign h_end = (h == H_LAST);
  assign v_end = (v == V_LAST);
  assign vis   = (h < H_VIS) && (v < V_VIS);
  assign hs_on = (h >= HS_BEG) && (h < HS_END);
  assign vs_on = (v >= VS_BEG) && (v < VS_END);

  logic [14:0]        h8;
  logic [2:0]         bar;
  logic [COLOR_W-1:0] grad;
  logic               tile;

  assign h8   = {h, 3'b000};
  assign bar  = 3'(h8 / 15'(H_ACTIVE));
  assign grad = COLOR_W'(h >> 6);
  assign tile = h[5] ^ v[5];

  logic [COLOR_W-1:0] sr, sg, sb;
  logic [COLOR_W-1:0] r_n, g_n, b_n;

  assign sr = {COLOR_W{sw_s[2]}};
  assign sg = {COLOR_W{sw_s[1]}};
  assign sb = {COLOR_W{sw_s[0]}};

  always_comb begin
    r_n = '0;
    g_n = '0;
    b_n = '0;
    unique case (mode_s)
      2'd0: begin
        r_n = sr;
        g_n = sg;
        b_n = sb;
      end
      2'd1: begin
        r_n = {COLOR_W{bar[2]}};
        g_n = {COLOR_W{bar[1]}};
        b_n = {COLOR_W{bar[0]}};
      end
      2'd2: begin
        r_n = tile ? '0 : sr;
        g_n = tile ? '0 : sg;
        b_n = tile ? '0 : sb;
      end
      2'd3: begin
        r_n = grad & sr;
        g_n = grad & sg;
        b_n = grad & sb;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      h               <= '0;
      v               <= '0;
      sw_s            <= '0;
      mode_s          <= '0;
      vid.h_sync      <= ~SYNC_POL;
      vid.v_sync      <= ~SYNC_POL;
      vid.red         <= '0;
      vid.green       <= '0;
      vid.blue        <= '0;
      vid.active      <= 1'b0;
      vid.frame_start <= 1'b0;
      vid.pix_x       <= '0;
      vid.pix_y       <= '0;
    end else begin
      if (h_end) begin
        h <= '0;
        v <= v_end ? '0 : v + 12'd1;
      end else begin
        h <= h + 12'd1;
      end
      // Latch pattern controls on the very last pixel so a frame never mixes
      if (h_end && v_end) begin
        sw_s   <= vid.sw;
        mode_s <= vid.mode;
      end
      vid.h_sync      <= hs_on ? SYNC_POL : ~SYNC_POL;
      vid.v_sync      <= vs_on ? SYNC_POL : ~SYNC_POL;
      vid.red         <= vis ? r_n : '0;
      vid.green       <= vis ? g_n : '0;
      vid.blue        <= vis ? b_n : '0;
      vid.active      <= vis;
      vid.frame_start <= (h == 12'd0) && (v == 12'd0);
      vid.pix_x       <= h;
      vid.pix_y       <= v;
    end
  end
endmodule

// File: tb/tb_vga_pattern_gen.sv
// Randomised bench for vga_pattern_gen: a frame-level reference model
// feeds a scoreboard queue that a negedge monitor drains.
module tb_vga_pattern_gen;
  localparam int HA = 256;
  localparam int HF = 4;
  localparam int HS = 8;
  localparam int HB = 4;
  localparam int VA = 40;
  localparam int VF = 2;
  localparam int VS = 3;
  localparam int VB = 3;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FRAME = HT * VT;
  localparam bit SP = 1'b0;

  typedef struct packed {
    logic        hs;
    logic        vs;
    logic        act;
    logic        fs;
    logic [11:0] x;
    logic [11:0] y;
    logic [3:0]  r;
    logic [3:0]  g;
    logic [3:0]  b;
  } obs_t;

  logic clk;
  logic rst;

  vga_pattern_gen_if #(.COLOR_W(4)) vid ();

  vga_pattern_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .COLOR_W(4), .SYNC_POL(SP)
  ) dut (
    .clk(clk),
    .rst(rst),
    .vid(vid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  obs_t q[$];
  int   ncmp = 0;
  int   nfail = 0;

  function automatic obs_t reset_obs();
    obs_t o;
    o = '0;
    o.hs = ~SP;
    o.vs = ~SP;
    return o;
  endfunction

  function automatic obs_t cur_obs();
    obs_t a;
    a = '{vid.h_sync, vid.v_sync, vid.active, vid.frame_start,
          vid.pix_x, vid.pix_y, vid.red, vid.green, vid.blue};
    return a;
  endfunction

  function automatic obs_t pix(int p, logic [2:0] s, logic [1:0] m);
    obs_t o;
    int x, y, bar;
    logic [3:0] sr, sg, sb, gr;
    x = p % HT;
    y = p / HT;
    o = '0;
    o.x = 12'(x);
    o.y = 12'(y);
    o.fs = (p == 0);
    o.act = (x < HA) && (y < VA);
    o.hs = (x >= HA + HF && x < HA + HF + HS) ? SP : ~SP;
    o.vs = (y >= VA + VF && y < VA + VF + VS) ? SP : ~SP;
    sr = s[2] ? 4'hF : 4'h0;
    sg = s[1] ? 4'hF : 4'h0;
    sb = s[0] ? 4'hF : 4'h0;
    case (m)
      2'd0: begin
        o.r = sr; o.g = sg; o.b = sb;
      end
      2'd1: begin
        bar = (x * 8) / HA;
        o.r = ((bar / 4) % 2) ? 4'hF : 4'h0;
        o.g = ((bar / 2) % 2) ? 4'hF : 4'h0;
        o.b = (bar % 2) ? 4'hF : 4'h0;
      end
      2'd2: begin
        if (((x / 32) + (y / 32)) % 2 == 0) begin
          o.r = sr; o.g = sg; o.b = sb;
        end
      end
      default: begin
        gr = 4'((x / 64) % 16);
        o.r = s[2] ? gr : 4'h0;
        o.g = s[1] ? gr : 4'h0;
        o.b = s[0] ? gr : 4'h0;
      end
    endcase
    if (!o.act) begin
      o.r = 4'h0; o.g = 4'h0; o.b = 4'h0;
    end
    return o;
  endfunction

  int         mp = 0;
  logic [2:0] msw = 3'd0;
  logic [1:0] mmode = 2'd0;

  always @(posedge clk) begin
    if (rst) begin
      q.push_back(reset_obs());
      mp = 0;
      msw = 3'd0;
      mmode = 2'd0;
    end else begin
      q.push_back(pix(mp, msw, mmode));
      if (mp == FRAME - 1) begin
        msw = vid.sw;
        mmode = vid.mode;
      end
      mp = (mp + 1) % FRAME;
    end
  end

  always @(negedge clk) begin
    obs_t e, a;
    if (q.size() > 0) begin
      e = q.pop_front();
      a = cur_obs();
      ncmp++;
      if (a !== e) begin
        nfail++;
        $display("FAIL pixel t=%0t got hs%b vs%b a%b fs%b x%0d y%0d rgb %h%h%h want hs%b vs%b a%b fs%b x%0d y%0d rgb %h%h%h",
          $time, a.hs, a.vs, a.act, a.fs, a.x, a.y, a.r, a.g, a.b,
          e.hs, e.vs, e.act, e.fs, e.x, e.y, e.r, e.g, e.b);
      end
    end
  end

  int gap = 0;

  always @(negedge clk) begin
    if (vid.frame_start === 1'b1) begin
      gap = 0;
    end else begin
      gap++;
      if (gap == FRAME + 8) begin
        ncmp++;
        nfail++;
        $display("FAIL timeout t=%0t no frame_start for %0d cycles",
          $time, gap);
      end
    end
  end

  initial begin
    obs_t ra;
    rst = 1'b1;
    vid.sw = 3'b100;
    vid.mode = 2'd0;
    repeat (3) @(negedge clk);
    ra = cur_obs();
    ncmp++;
    if (ra !== reset_obs()) begin
      nfail++;
      $display("FAIL reset t=%0t outputs %h not reset values", $time, ra);
    end
    rst = 1'b0;
    for (int f = 0; f < 5; f++) begin
      for (int k = 0; k < FRAME; k++) begin
        @(negedge clk);
        if ($urandom_range(0, 3000) == 0) begin
          vid.sw = 3'($urandom);
          vid.mode = 2'($urandom);
        end
        if (k == FRAME - 2) begin
          vid.sw = 3'($urandom_range(1, 7));
          vid.mode = 2'((f + 1) % 4);
        end
        if (f == 3 && k == 4000) rst = 1'b1;
        if (f == 3 && k == 4003) rst = 1'b0;
      end
    end
    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule

// File: doc/vga_pattern_gen.md
VGA_PATTERN_GEN -- requirements
Module: vga_pattern_gen

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640, visible pixels per line.
REQ-002 SHALL have parameters H_FP/H_SYNC/H_BP, defaults 16/96/48, horizontal front porch, sync and back porch in pixels.
REQ-003 SHALL have parameter V_ACTIVE, default 480, visible lines per frame.
REQ-004 SHALL have parameters V_FP/V_SYNC/V_BP, defaults 10/2/33, vertical front porch, sync and back porch in lines.
REQ-005 SHALL have parameter COLOR_W, default 4, bits per colour channel (1..8).
REQ-006 SHALL have parameter SYNC_POL, default 0, asserted sync level (0 = active-low).
REQ-007 SHALL have port clk, input, 1, pixel clock; the only clock.
REQ-008 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-009 SHALL have port sw, input, 3, colour select {R,G,B}.
REQ-010 SHALL have port mode, input, 2, pattern select.
REQ-011 SHALL have ports h_sync and v_sync, output, 1 each, sync pulses.
REQ-012 SHALL have ports red, green and blue, output, COLOR_W each, pixel colour.
REQ-013 SHALL have port active, output, 1, high while the current pixel is visible.
REQ-014 SHALL have port frame_start, output, 1, one-cycle pulse on pixel (0,0).
REQ-015 SHALL have ports pix_x and pix_y, output, 12 each, coordinates of the current output pixel.

Function
REQ-016 SHALL run a horizontal counter h 0..H_TOTAL-1 (H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP), incrementing every clk and wrapping to 0.
REQ-017 SHALL run a vertical counter v 0..V_TOTAL-1 that increments only on an h wrap and wraps to 0 after V_TOTAL-1.
REQ-018 SHALL register every output exactly 1 cycle after the counter state it describes; pix_x/pix_y equal that h/v.
REQ-019 SHALL assert h_sync (= SYNC_POL) for h in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1]; otherwise drive it to ~SYNC_POL.
REQ-020 SHALL assert v_sync for v in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1] for full lines, with h_sync-equivalent polarity.
REQ-021 SHALL set active = (h < H_ACTIVE) && (v < V_ACTIVE); when active = 0, red/green/blue SHALL all be 0.
REQ-022 SHALL sample sw and mode into shadow registers only on the cycle with h = H_TOTAL-1 and v = V_TOTAL-1; the new values SHALL apply from the next pixel (0,0), so a frame is never mixed.
REQ-023 SHALL, in mode 0 (solid), drive each channel to all-ones if its shadow sw bit is set, else 0.
REQ-024 SHALL, in mode 1 (colour bars), compute bar index b = (h*8)/H_ACTIVE (0..7) and drive red = b[2], green = b[1] and blue = b[0], each replicated to full scale; sw is ignored.
REQ-025 SHALL, in mode 2 (checker), compute c = h[5]^v[5] (32x32 tiles); c = 0 SHALL give the solid shadow-sw colour and c = 1 SHALL give black.
REQ-026 SHALL, in mode 3 (gradient), compute g = h[COLOR_W+5:6] (truncated to COLOR_W bits), and each channel SHALL equal g if its shadow sw bit is set, else 0.
REQ-027 SHALL pulse frame_start high for exactly 1 cycle per frame, the cycle when pix_x = 0 and pix_y = 0.

Reset
REQ-028 SHALL, on a clk edge with rst = 1, set h = 0 and v = 0, shadow sw = 0 and shadow mode = 0.
REQ-029 SHALL, on the same reset edge, drive outputs h_sync = v_sync = ~SYNC_POL, red = green = blue = 0, active = 0, frame_start = 0 and pix_x = pix_y = 0.
REQ-030 SHALL, on the first cycle after rst falls, output pixel (0,0) with frame_start = 1; reset mid-frame SHALL restart the frame the same way.

Verification
REQ-031 Defaults, sw = 100, mode = 0 -> h_sync low for 96 cycles starting 656 cycles after frame_start, with period 800; red = 4'hF and green = blue = 0 while active; 640 active cycles per line.
REQ-032 Defaults -> v_sync low for 1600 cycles starting at line 490; frame_start period 420000 cycles; active never high at lines 480..524.
REQ-033 mode = 1 -> at pix_x = 0, rgb = 0/0/0; at 80, blue = F; at 320, red = F; at 639, all = F; at 640, all = 0.
REQ-034 mode = 2, sw = 010 -> at (0,0) green = F; at (32,0) all = 0; at (32,32) green = F.
REQ-035 Change sw from 100 to 001 at line 200 -> the rest of the frame stays red; the first pixel after the next frame_start is blue.
REQ-036 rst pulsed for 3 cycles at line 300, pixel 100 -> outputs hold their reset values during reset; the cycle after release gives frame_start = 1 and pix_x = pix_y = 0; shadow mode = 0, so output is black until sw is resampled at the frame end.
